// File: rtl/fifo_read_packer.sv
`default_nettype none
// fifo_read_packer: drains a FIFO read port and packs RATIO narrow words into one wide word.
// The wide word goes out on valid/ready; a flush emits a partial word with a lane keep mask.
module fifo_read_packer #(
  parameter int NARROW_WIDTH = 8,
  parameter int RATIO        = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           empty_i,
  input  logic [NARROW_WIDTH-1:0]        read_data_i,
  output logic                           read_o,
  input  logic                           flush_i,
  output logic                           wide_valid_o,
  input  logic                           wide_ready_i,
  output logic [NARROW_WIDTH*RATIO-1:0]  wide_data_o,
  output logic [RATIO-1:0]               wide_keep_o
);

  localparam int WIDE_WIDTH = NARROW_WIDTH * RATIO;
  localparam int ASM_WIDTH  = NARROW_WIDTH * (RATIO - 1);
  localparam int LANE_W     = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  typedef enum logic [0:0] {
    IDLE_FILL  = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [ASM_WIDTH-1:0]    asm_q, asm_d;
  logic                    out_free, last_lane, pop, complete;
  logic                    flush_accept, load_full, load_partial;
  logic [LANE_W-1:0]       fill_cnt;
  logic [WIDE_WIDTH-1:0]   part_data;
  logic [RATIO-1:0]        part_keep;

  assign out_free  = ~wide_valid_o | wide_ready_i;
  assign last_lane = (lane_q == LAST_LANE);
  // The final lane bypasses the assembly register, so it may only pop when the output can load.
  assign pop       = reset_ni & ~empty_i & (state_q != FLUSH_WAIT) & (~last_lane | out_free);
  assign complete  = pop & last_lane;
  assign fill_cnt  = lane_q + LANE_W'(pop);
  assign read_o    = pop;

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    flush_accept = 1'b0;
    load_full    = 1'b0;
    load_partial = 1'b0;
    case (state_q)
      IDLE_FILL: begin
        // A flush that coincides with a completing pop is absorbed by that completion.
        flush_accept = flush_i & ~complete & (pop | (lane_q != '0));
        if (complete) begin
          load_full = 1'b1;
          lane_d    = '0;
        end else if (flush_accept) begin
          if (out_free) begin
            load_partial = 1'b1;
            lane_d       = '0;
          end else begin
            state_d = FLUSH_WAIT;
            lane_d  = fill_cnt;
          end
        end else if (pop) begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      FLUSH_WAIT: begin
        if (out_free) begin
          load_partial = 1'b1;
          lane_d       = '0;
          state_d      = IDLE_FILL;
        end
      end
      default: state_d = IDLE_FILL;
    endcase
  end

  // Partial word is built from the assembly lanes including any word popped this cycle.
  always_comb begin
    asm_d     = asm_q;
    part_data = '0;
    part_keep = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (pop && !last_lane && (lane_q == LANE_W'(k))) begin
        asm_d[k*NARROW_WIDTH +: NARROW_WIDTH] = read_data_i;
      end
      if (LANE_W'(k) < fill_cnt) begin
        part_data[k*NARROW_WIDTH +: NARROW_WIDTH] = asm_d[k*NARROW_WIDTH +: NARROW_WIDTH];
        part_keep[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE_FILL;
      lane_q       <= '0;
      asm_q        <= '0;
      wide_valid_o <= 1'b0;
      wide_data_o  <= '0;
      wide_keep_o  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      if (load_full) begin
        wide_data_o  <= {read_data_i, asm_q};
        wide_keep_o  <= '1;
        wide_valid_o <= 1'b1;
      end else if (load_partial) begin
        wide_data_o  <= part_data;
        wide_keep_o  <= part_keep;
        wide_valid_o <= 1'b1;
      end else if (wide_ready_i) begin
        wide_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
